// File: rtl/dotp_pkg.sv
// Shared types and default widths for the dot-product pipeline and its window accumulator.
package dotp_pkg;

    localparam int DOTP_IN_W  = 17;
    localparam int DOTP_CNT_W = 8;
    localparam int DOTP_ACC_W = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/dotp_sat_add.sv
// Combinational accumulator adder: zero-extended term plus running total, with carry out.
// With DOTP_ACCUM_SAT_EN defined the sum clamps to all-ones on carry; otherwise it wraps.
module dotp_sat_add #(
    parameter int ACC_W = 25,
    parameter int IN_W  = 17
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  data,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + (ACC_W+1)'(data);
    assign carry = wide[ACC_W];

`ifdef DOTP_ACCUM_SAT_EN
    assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/dotp_accum.sv
// Sums a programmable-length window of pipeline results and hands the total downstream
// on a valid/ready port. Overflow behaviour selected by DOTP_ACCUM_SAT_EN (saturate vs. wrap).
module dotp_accum
    import dotp_pkg::*;
#(
    parameter int IN_W  = DOTP_IN_W,
    parameter int CNT_W = DOTP_CNT_W,
    parameter int ACC_W = DOTP_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             overflow,
    output logic             busy
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             last_term;

    dotp_sat_add #(
        .ACC_W(ACC_W),
        .IN_W (IN_W)
    ) u_add (
        .acc  (acc),
        .data (in_data),
        .sum  (add_sum),
        .carry(add_carry)
    );

    assign last_term = (cnt == len_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            len_q <= len;
                            state <= ACCUM;
                        end else begin
                            // empty window completes immediately with a zero total
                            out_sum   <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= add_sum;
                        cnt <= cnt + 1'b1;
                        if (add_carry)
                            overflow <= 1'b1;
                        if (last_term) begin
                            out_sum   <= add_sum;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // start here is dropped; a new window must be requested from IDLE
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dotp_accum.sv
// Directed bench for dotp_accum: default-width instance plus a narrow ACC_W=20 instance for overflow.
module tb_dotp_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [16:0] in_data;
    logic        out_ready;

    logic        out_valid;
    logic [24:0] out_sum;
    logic        overflow;
    logic        busy;

    logic        n_out_valid;
    logic [19:0] n_out_sum;
    logic        n_overflow;
    logic        n_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dotp_accum dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .overflow(overflow), .busy(busy)
    );

    dotp_accum #(.IN_W(17), .CNT_W(8), .ACC_W(20)) dut_n (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_sum(n_out_sum), .overflow(n_overflow), .busy(n_busy)
    );

    // advance one edge; inputs set after this are sampled at the next edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_sum !== 25'd0) begin bad++; $display("FAIL reset_sum got=%0d exp=0", out_sum); end
        total++; if (overflow !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", overflow, busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        start = 1'b1; len = 8'd4; out_ready = 1'b0;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        in_valid = 1'b1;
        in_data = 17'd100; step();
        in_data = 17'd200; step();
        in_data = 17'd300; step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        in_data = 17'd400; step();
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_sum !== 25'd1000) begin bad++; $display("FAIL basic_sum got=%0d exp=1000", out_sum); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b%b exp=00", out_valid, busy); end
        total++; if (out_sum !== 25'd1000) begin bad++; $display("FAIL basic_sum_keep got=%0d exp=1000", out_sum); end
    endtask

    task automatic test_gapped();
        in_valid = 1'b1; in_data = 17'd999;
        step(); step();
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL gap_idle_ignore got=%b%b exp=00", busy, out_valid); end
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        in_data = 17'h1FFFF; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 17'd5; step();
        in_valid = 1'b0; step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_early_valid got=%b exp=0", out_valid); end
        in_valid = 1'b1; in_data = 17'd7; step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_sum !== 25'd131083) begin bad++; $display("FAIL gap_sum got=%b/%0d exp=1/131083", out_valid, out_sum); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0; in_valid = 1'b1;
        in_data = 17'd10; step();
        in_data = 17'd20; step();
        for (int i = 0; i < 5; i++) begin
            start = i[0]; len = 8'd7; in_valid = 1'b1; in_data = 17'd55;
            step();
            total++; if (out_valid !== 1'b1 || out_sum !== 25'd30 || busy !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%0d/%b exp=1/30/1", i, out_valid, out_sum, busy);
            end
        end
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release got=%b%b exp=00", out_valid, busy); end
        step();
        total++; if (busy !== 1'b0 || out_sum !== 25'd30) begin bad++; $display("FAIL bp_no_window got=%b/%0d exp=0/30", busy, out_sum); end
    endtask

    task automatic test_len_limits();
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        total++; if (out_valid !== 1'b1 || out_sum !== 25'd0 || busy !== 1'b1) begin bad++; $display("FAIL zero_len got=%b/%0d/%b exp=1/0/1", out_valid, out_sum, busy); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        start = 1'b1; len = 8'd255;
        step();
        start = 1'b0; in_valid = 1'b1; in_data = 17'h1FFFF;
        for (int i = 0; i < 254; i++) step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL max_early_valid got=%b exp=0", out_valid); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_sum !== 25'd33423105) begin bad++; $display("FAIL max_sum got=%b/%0d exp=1/33423105", out_valid, out_sum); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL max_ovf got=%b exp=0", overflow); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [19:0] exp_n;
`ifdef DOTP_ACCUM_SAT_EN
        exp_n = 20'hFFFFF;
`else
        exp_n = 20'd1048560;
`endif
        start = 1'b1; len = 8'd16;
        step();
        start = 1'b0;
        total++; if (n_overflow !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b exp=0", n_overflow); end
        in_valid = 1'b1; in_data = 17'h1FFFF;
        for (int i = 0; i < 16; i++) step();
        in_valid = 1'b0;
        total++; if (n_out_valid !== 1'b1 || n_out_sum !== exp_n) begin bad++; $display("FAIL ovf_sum got=%b/%0d exp=1/%0d", n_out_valid, n_out_sum, exp_n); end
        total++; if (n_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", n_overflow); end
        total++; if (out_sum !== 25'd2097136 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_wide got=%0d/%b exp=2097136/0", out_sum, overflow); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        total++; if (n_overflow !== 1'b1 || n_out_sum !== exp_n) begin bad++; $display("FAIL ovf_keep got=%b/%0d exp=1/%0d", n_overflow, n_out_sum, exp_n); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0; in_valid = 1'b1;
        in_data = 17'd50; step();
        in_data = 17'd60; step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 25'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%b/%0d/%b exp=0/0/0/0", busy, out_valid, out_sum, overflow);
        end
        total++; if (n_overflow !== 1'b0 || n_out_sum !== 20'd0) begin bad++; $display("FAIL rstmid_narrow got=%b/%0d exp=0/0", n_overflow, n_out_sum); end
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0; in_valid = 1'b1;
        in_data = 17'd1; step();
        in_data = 17'd2; step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_sum !== 25'd3) begin bad++; $display("FAIL rstmid_new got=%b/%0d exp=1/3", out_valid, out_sum); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_len_limits();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
